// File: rtl/univ_shift_reg_ne.sv
// Falling-edge universal shift register (hold / shift right / shift left / load)
// with a saturating shift counter that flags a full word shifted since load/reset.
module univ_shift_reg_ne #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             C,
    input  logic             RE,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             SO_R,
    output logic             SO_L,
    output logic             DONE
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt;
    logic             done_r;
    logic             cnt_full;
    mode_e            mode;

    assign mode     = mode_e'(MODE);
    assign cnt_full = (cnt_r == CW'(WIDTH));

    // Next register contents and shift count
    always_comb begin
        q_nxt   = q_r;
        cnt_nxt = cnt_r;
        case (mode)
            MODE_HOLD: begin
                q_nxt   = q_r;
                cnt_nxt = cnt_r;
            end
            MODE_SHR: begin
                q_nxt   = {SIR, q_r[WIDTH-1:1]};
                cnt_nxt = cnt_full ? cnt_r : cnt_r + CW'(1);
            end
            MODE_SHL: begin
                q_nxt   = {q_r[WIDTH-2:0], SIL};
                cnt_nxt = cnt_full ? cnt_r : cnt_r + CW'(1);
            end
            MODE_LOAD: begin
                q_nxt   = D;
                cnt_nxt = '0;
            end
            default: begin
                q_nxt   = q_r;
                cnt_nxt = cnt_r;
            end
        endcase
    end

    // DONE is registered alongside the count so it never glitches
    always_ff @(negedge C or posedge RE) begin
        if (RE) begin
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            done_r <= (cnt_nxt == CW'(WIDTH));
        end
    end

    assign Q    = q_r;
    assign Qnot = ~q_r;
    assign SO_R = q_r[0];
    assign SO_L = q_r[WIDTH-1];
    assign DONE = done_r;

endmodule

// File: tb/tb_univ_shift_reg_ne.sv
// Bench for univ_shift_reg_ne: directed scenarios plus random traffic against
// a plain-arithmetic model of the register contents and shift count.
module tb_univ_shift_reg_ne;

    localparam int unsigned W = 4;

    logic         C;
    logic         RE;
    logic [1:0]   MODE;
    logic [W-1:0] D;
    logic         SIR;
    logic         SIL;
    logic [W-1:0] Q;
    logic [W-1:0] Qnot;
    logic         SO_R;
    logic         SO_L;
    logic         DONE;

    int           checks = 0;
    int           errors = 0;
    int           q_m;
    int           cnt_m;

    univ_shift_reg_ne #(.WIDTH(W)) dut (
        .C    (C),
        .RE   (RE),
        .MODE (MODE),
        .D    (D),
        .SIR  (SIR),
        .SIL  (SIL),
        .Q    (Q),
        .Qnot (Qnot),
        .SO_R (SO_R),
        .SO_L (SO_L),
        .DONE (DONE)
    );

    initial C = 1'b1;
    always #5 C = ~C;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int mask;
        mask = (1 << W) - 1;
        check({tag, "_q"},    32'(Q),    32'(q_m & mask));
        check({tag, "_qnot"}, 32'(Qnot), 32'(~q_m & mask));
        check({tag, "_so_r"}, 32'(SO_R), 32'(q_m & 1));
        check({tag, "_so_l"}, 32'(SO_L), 32'((q_m >> (W - 1)) & 1));
        check({tag, "_done"}, 32'(DONE), 32'(cnt_m == W));
    endtask

    // One functional falling edge with the given inputs, then model update and check
    task automatic step(input string tag, input logic [1:0] m, input logic [W-1:0] d,
                        input logic sir, input logic sil);
        @(posedge C);
        #1;
        MODE = m;
        D    = d;
        SIR  = sir;
        SIL  = sil;
        check({tag, "_pre_so_r"}, 32'(SO_R), 32'(q_m & 1));
        @(negedge C);
        case (m)
            2'd1: begin
                q_m   = (q_m >> 1) + (int'(sir) << (W - 1));
                cnt_m = (cnt_m < W) ? cnt_m + 1 : cnt_m;
            end
            2'd2: begin
                q_m   = ((q_m * 2) + int'(sil)) % (1 << W);
                cnt_m = (cnt_m < W) ? cnt_m + 1 : cnt_m;
            end
            2'd3: begin
                q_m   = int'(d);
                cnt_m = 0;
            end
            default: ;
        endcase
        #1;
        check_all(tag);
        MODE = 2'd0;
    endtask

    // Reset pulsed between edges; optionally held across one falling edge
    task automatic pulse_reset(input string tag, input bit across_edge);
        @(posedge C);
        #2;
        RE = 1'b1;
        #1;
        q_m   = 0;
        cnt_m = 0;
        check_all({tag, "_async"});
        if (across_edge) begin
            MODE = 2'd3;
            D    = '1;
            @(negedge C);
            #1;
            check_all({tag, "_edge_ignored"});
            MODE = 2'd0;
            @(posedge C);
            #1;
            check_all({tag, "_rise"});
        end
        #1;
        RE = 1'b0;
    endtask

    initial begin
        RE    = 1'b1;
        MODE  = 2'd0;
        D     = '0;
        SIR   = 1'b0;
        SIL   = 1'b0;
        q_m   = 0;
        cnt_m = 0;
        #3;
        check_all("por");
        check("por_q_const", 32'(Q), 32'h0);
        check("por_qnot_const", 32'(Qnot), 32'hF);
        @(posedge C);
        #2;
        RE = 1'b0;

        // Load, then confirm a rising edge alone changes nothing
        step("load", 2'd3, 4'b1011, 1'b0, 1'b0);
        check("load_q_const", 32'(Q), 32'hB);
        check("load_qnot_const", 32'(Qnot), 32'h4);
        MODE = 2'd3;
        D    = 4'b0000;
        @(posedge C);
        #1;
        check("rise_only_q", 32'(Q), 32'hB);
        MODE = 2'd0;

        // Shift right four times: DONE only after the fourth
        step("shr1", 2'd1, '0, 1'b0, 1'b0);
        check("shr1_q_const", 32'(Q), 32'h5);
        step("shr2", 2'd1, '0, 1'b0, 1'b0);
        step("shr3", 2'd1, '0, 1'b0, 1'b0);
        check("shr3_done_const", 32'(DONE), 32'h0);
        step("shr4", 2'd1, '0, 1'b0, 1'b0);
        check("shr4_q_const", 32'(Q), 32'h0);
        check("shr4_done_const", 32'(DONE), 32'h1);

        // Shift left five times from a fresh load; count saturates
        step("ld0", 2'd3, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("shl", 2'd2, '0, 1'b0, 1'b1);
        check("shl5_q_const", 32'(Q), 32'hF);
        check("shl5_done_const", 32'(DONE), 32'h1);
        step("ld6", 2'd3, 4'b0110, 1'b0, 1'b0);
        check("ld6_done_const", 32'(DONE), 32'h0);

        // Mixed directions and holds
        step("ld8", 2'd3, 4'b1000, 1'b0, 1'b0);
        step("mix_r", 2'd1, '0, 1'b1, 1'b0);
        check("mix_r_q_const", 32'(Q), 32'hC);
        step("mix_l", 2'd2, '0, 1'b0, 1'b0);
        check("mix_l_q_const", 32'(Q), 32'h8);
        for (int i = 0; i < 3; i++) step("hold", 2'd0, 4'b1111, 1'b1, 1'b1);
        check("hold_done_const", 32'(DONE), 32'h0);
        step("mix3", 2'd1, '0, 1'b0, 1'b0);
        step("mix4", 2'd2, '0, 1'b0, 1'b0);
        check("mix4_done_const", 32'(DONE), 32'h1);

        // Reset mid-operation, including a falling edge under reset
        step("ld9", 2'd3, 4'b1001, 1'b0, 1'b0);
        step("pre_rst1", 2'd1, '0, 1'b1, 1'b0);
        step("pre_rst2", 2'd1, '0, 1'b1, 1'b0);
        pulse_reset("rst_mid", 1'b1);
        for (int i = 0; i < 3; i++) step("post_rst", 2'd2, '0, 1'b0, 1'b1);
        check("post_rst3_done_const", 32'(DONE), 32'h0);
        step("post_rst4", 2'd1, '0, 1'b1, 1'b0);
        check("post_rst4_done_const", 32'(DONE), 32'h1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) begin
                pulse_reset("rnd_rst", 1'($urandom_range(1)));
            end else begin
                step("rnd", 2'($urandom_range(3)), W'($urandom),
                     1'($urandom_range(1)), 1'($urandom_range(1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
